// File: rtl/opfetch_scoreboard.sv
// Operand-fetch stage with a register scoreboard: issues decoded instructions
// into a one-entry output slot, stalling on RAW/WAW hazards against in-flight writes.
module opfetch_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_has_rd,
    output logic              re1,
    output logic              re2,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_has_rd
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   clr_vec;
    logic [NREG-1:0]   eff_busy;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d;
    logic [DATA_W-1:0] out_op2_q, out_op2_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_has_rd_q, out_has_rd_d;
    logic              hazard;
    logic              fire;

    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;
    assign re1    = in_valid & in_use_rs1;
    assign re2    = in_valid & in_use_rs2;

    // The register file forwards same-cycle writes, so a retiring writer never stalls its reader.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
        clr_vec = '0;
        if (wb_we && (wb_addr != '0)) clr_vec[wb_addr] = 1'b1;
    end

    assign eff_busy = busy_q & ~clr_vec;

    assign hazard = (in_use_rs1 & (in_rs1 != '0) & eff_busy[in_rs1])
                  | (in_use_rs2 & (in_rs2 != '0) & eff_busy[in_rs2])
                  | (in_has_rd  & (in_rd  != '0) & eff_busy[in_rd]);

    assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | out_ready);
    assign fire     = in_valid & in_ready;

    always_comb begin
        busy_d       = eff_busy;
        out_valid_d  = out_valid_q;
        out_op1_d    = out_op1_q;
        out_op2_d    = out_op2_q;
        out_rd_d     = out_rd_q;
        out_has_rd_d = out_has_rd_q;

        if (flush) begin
            // The discarded instruction will never write back, so release its destination.
            out_valid_d = 1'b0;
            if (out_valid_q && out_has_rd_q && (out_rd_q != '0)) busy_d[out_rd_q] = 1'b0;
        end else if (fire) begin
            out_valid_d  = 1'b1;
            out_op1_d    = in_use_rs1 ? rdata1 : '0;
            out_op2_d    = in_use_rs2 ? rdata2 : '0;
            out_rd_d     = in_rd;
            out_has_rd_d = in_has_rd;
            // Applied after the writeback clear so a same-edge set of the same index wins.
            if (in_has_rd && (in_rd != '0)) busy_d[in_rd] = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_rd_q     <= '0;
            out_has_rd_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_rd_q     <= out_rd_d;
            out_has_rd_q <= out_has_rd_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op1    = out_op1_q;
    assign out_op2    = out_op2_q;
    assign out_rd     = out_rd_q;
    assign out_has_rd = out_has_rd_q;

endmodule

// File: tb/tb_opfetch_scoreboard.sv
// Directed bench for opfetch_scoreboard: per-scenario tasks with hand-computed
// expectations for issue, hazards, stalls, flush and same-edge busy updates.
module tb_opfetch_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2, in_has_rd;
    logic              re1, re2;
    logic [ADDR_W-1:0] raddr1, raddr2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1, out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_has_rd;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    opfetch_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_use_rs1 (in_use_rs1),
        .in_use_rs2 (in_use_rs2),
        .in_has_rd  (in_has_rd),
        .re1        (re1),
        .re2        (re2),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_rd     (out_rd),
        .out_has_rd (out_has_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_use_rs1 = 1'b0;
        in_use_rs2 = 1'b0;
        in_has_rd  = 1'b0;
        rdata1     = '0;
        rdata2     = '0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        out_ready  = 1'b1;
    endtask

    task automatic drive_instr(input logic [ADDR_W-1:0] rs1, input logic u1, input logic [DATA_W-1:0] d1,
                               input logic [ADDR_W-1:0] rs2, input logic u2, input logic [DATA_W-1:0] d2,
                               input logic [ADDR_W-1:0] rd, input logic hrd);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_use_rs1 = u1;
        rdata1     = d1;
        in_rs2     = rs2;
        in_use_rs2 = u2;
        rdata2     = d2;
        in_rd      = rd;
        in_has_rd  = hrd;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        drive_instr(5'd1, 1'b1, 32'h1111, 5'd2, 1'b1, 32'h2222, 5'd3, 1'b1);
        wb_we = 1'b1; wb_addr = 5'd3; flush = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++;
        if ({out_op1, out_op2, out_rd, out_has_rd} !== '0) begin
            tests_failed++;
            $display("FAIL reset_slot: op1=%h op2=%h rd=%0d has_rd=%0b want all 0", out_op1, out_op2, out_rd, out_has_rd);
        end
        tests_run++;
        if (dut.busy_q !== 32'h0) begin tests_failed++; $display("FAIL reset_busy: got %h want 0", dut.busy_q); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_issue();
        out_ready = 1'b0;
        drive_instr(5'd1, 1'b1, 32'd10, 5'd2, 1'b1, 32'd20, 5'd5, 1'b1);
        #1;
        tests_run++;
        if ({re1, re2, raddr1, raddr2} !== {1'b1, 1'b1, 5'd1, 5'd2}) begin
            tests_failed++;
            $display("FAIL issue_read_req: re1=%0b re2=%0b a1=%0d a2=%0d want 1 1 1 2", re1, re2, raddr1, raddr2);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL issue_in_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_op1, out_op2, out_rd, out_has_rd} !== {1'b1, 32'd10, 32'd20, 5'd5, 1'b1}) begin
            tests_failed++;
            $display("FAIL issue_slot: v=%0b op1=%0d op2=%0d rd=%0d hrd=%0b want 1 10 20 5 1",
                     out_valid, out_op1, out_op2, out_rd, out_has_rd);
        end
        tests_run++;
        if (dut.busy_q !== 32'h0000_0020) begin tests_failed++; $display("FAIL issue_busy: got %h want 00000020", dut.busy_q); end
    endtask

    task automatic test_raw_hazard();
        out_ready = 1'b1;
        drive_instr(5'd5, 1'b1, 32'hDEAD, 5'd0, 1'b0, 32'h77, 5'd6, 1'b1);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall0: in_ready got %0b want 0", in_ready); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL raw_drain: out_valid got %0b want 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall1: in_ready got %0b want 0", in_ready); end
        wb_we = 1'b1; wb_addr = 5'd5; rdata1 = 32'h33;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_bypass_ready: got %0b want 1", in_ready); end
        tick();
        idle_inputs();
        tests_run++;
        if ({out_valid, out_op1, out_op2, out_rd} !== {1'b1, 32'h33, 32'h0, 5'd6}) begin
            tests_failed++;
            $display("FAIL raw_slot: v=%0b op1=%h op2=%h rd=%0d want 1 33 0 6", out_valid, out_op1, out_op2, out_rd);
        end
        tests_run++;
        if (dut.busy_q !== 32'h0000_0040) begin tests_failed++; $display("FAIL raw_busy: got %h want 00000040", dut.busy_q); end
    endtask

    task automatic test_x0();
        drive_instr(5'd3, 1'b1, 32'h11, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL x0_write_ready: got %0b want 1", in_ready); end
        tick();
        tests_run++;
        if ({out_valid, out_rd, dut.busy_q[0]} !== {1'b1, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL x0_write: v=%0b rd=%0d busy0=%0b want 1 0 0", out_valid, out_rd, dut.busy_q[0]);
        end
        drive_instr(5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL x0_read_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_op1, out_op2} !== {1'b1, 32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL x0_read_slot: v=%0b op1=%h op2=%h want 1 0 0", out_valid, out_op1, out_op2);
        end
        tests_run++;
        if (dut.busy_q !== 32'h0000_0040) begin tests_failed++; $display("FAIL x0_busy: got %h want 00000040", dut.busy_q); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_instr(5'd3, 1'b1, 32'hAAAA, 5'd4, 1'b1, 32'hBBBB, 5'd10, 1'b1);
        tick();
        out_ready = 1'b0;
        drive_instr(5'd1, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready_%0d: got %0b want 0", i, in_ready); end
            tick();
            tests_run++;
            if ({out_valid, out_op1, out_op2, out_rd} !== {1'b1, 32'hAAAA, 32'hBBBB, 5'd10}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: v=%0b op1=%h op2=%h rd=%0d want 1 aaaa bbbb 10",
                         i, out_valid, out_op1, out_op2, out_rd);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready0: got %0b want 1", in_ready); end
        tick();
        tests_run++;
        if ({out_valid, out_op1, out_rd} !== {1'b1, 32'h1, 5'd11}) begin
            tests_failed++;
            $display("FAIL b2b_first: v=%0b op1=%h rd=%0d want 1 1 11", out_valid, out_op1, out_rd);
        end
        drive_instr(5'd2, 1'b1, 32'h2, 5'd0, 1'b0, 32'h0, 5'd12, 1'b1);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready1: got %0b want 1", in_ready); end
        tick();
        tests_run++;
        if ({out_valid, out_op1, out_rd} !== {1'b1, 32'h2, 5'd12}) begin
            tests_failed++;
            $display("FAIL b2b_second: v=%0b op1=%h rd=%0d want 1 2 12", out_valid, out_op1, out_rd);
        end
        idle_inputs();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: out_valid got %0b want 0", out_valid); end
        tests_run++;
        if (dut.busy_q !== 32'h0000_1C40) begin tests_failed++; $display("FAIL b2b_busy: got %h want 00001c40", dut.busy_q); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd7, 1'b1);
        tick();
        tests_run++;
        if ({out_valid, out_rd, dut.busy_q[7]} !== {1'b1, 5'd7, 1'b1}) begin
            tests_failed++;
            $display("FAIL flush_setup: v=%0b rd=%0d busy7=%0b want 1 7 1", out_valid, out_rd, dut.busy_q[7]);
        end
        drive_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd8, 1'b1);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
        tick();
        idle_inputs();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        tests_run++;
        if (dut.busy_q !== 32'h0000_1C40) begin tests_failed++; $display("FAIL flush_busy: got %h want 00001c40", dut.busy_q); end
    endtask

    task automatic test_same_edge();
        out_ready = 1'b1;
        drive_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd9, 1'b1);
        tick();
        tests_run++;
        if (dut.busy_q !== 32'h0000_1E40) begin tests_failed++; $display("FAIL same_setup_busy: got %h want 00001e40", dut.busy_q); end
        drive_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd9, 1'b1);
        wb_we = 1'b1; wb_addr = 5'd9;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL same_waw_bypass: in_ready got %0b want 1", in_ready); end
        tick();
        idle_inputs();
        tests_run++;
        if ({out_valid, out_rd, dut.busy_q} !== {1'b1, 5'd9, 32'h0000_1E40}) begin
            tests_failed++;
            $display("FAIL same_set_wins: v=%0b rd=%0d busy=%h want 1 9 00001e40", out_valid, out_rd, dut.busy_q);
        end
        wb_we = 1'b1; wb_addr = 5'd20;
        tick();
        tests_run++;
        if (dut.busy_q !== 32'h0000_1E40) begin tests_failed++; $display("FAIL wb_idle_reg: busy got %h want 00001e40", dut.busy_q); end
        wb_addr = 5'd6;
        tick();
        wb_we = 1'b0;
        tests_run++;
        if (dut.busy_q !== 32'h0000_1E00) begin tests_failed++; $display("FAIL wb_clear6: busy got %h want 00001e00", dut.busy_q); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive_instr(5'd1, 1'b1, 32'h5A5A, 5'd0, 1'b0, 32'h0, 5'd13, 1'b1);
        tick();
        tests_run++;
        if ({out_valid, out_op1} !== {1'b1, 32'h5A5A}) begin
            tests_failed++;
            $display("FAIL rst_stall_setup: v=%0b op1=%h want 1 5a5a", out_valid, out_op1);
        end
        rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd13;
        drive_instr(5'd2, 1'b1, 32'h9, 5'd0, 1'b0, 32'h0, 5'd14, 1'b1);
        tick();
        tests_run++;
        if ({out_valid, out_op1, out_rd, dut.busy_q} !== {1'b0, 32'h0, 5'd0, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_stall: v=%0b op1=%h rd=%0d busy=%h want 0 0 0 0", out_valid, out_op1, out_rd, dut.busy_q);
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_issue();
        test_raw_hazard();
        test_x0();
        test_back_to_back();
        test_flush();
        test_same_edge();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
